// File: rtl/uart_fifo_tx_if.sv
// FIFO read-side port bundle for uart_fifo_tx: first-word-fall-through head word,
// empty flag and the pop strobe driven back by the transmitter.
interface uart_fifo_tx_if #(
  parameter int unsigned W = 8
);
  logic         empty;
  logic [W-1:0] data_in;
  logic         do_pop;

  // master: the transmitter that pops; slave: the FIFO that supplies words
  modport master (input empty, input data_in, output do_pop);
  modport slave  (output empty, output data_in, input do_pop);
endinterface

// File: rtl/uart_fifo_tx.sv
// UART 8N1/8N2 transmitter draining a first-word-fall-through FIFO, one pop per frame,
// with back-to-back frames and no idle gap while words are available.
module uart_fifo_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned W            = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  uart_fifo_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           done
);
  localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_MAX = (W > STOP_BITS) ? W : STOP_BITS;
  localparam int unsigned BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [W-1:0]      shreg, shreg_n;
  logic              tx_n, done_n;
  logic              baud_last, frame_end, pop;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && baud_last && (bit_cnt == STOP_LAST);

  // Gated by reset so no pop can reach the FIFO while the frame state is being cleared.
  assign pop         = ~reset & enable & ~fifo.empty & ((state == IDLE) | frame_end);
  assign fifo.do_pop = pop;
  assign busy        = (state != IDLE);

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + 1'b1;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    tx_n       = tx;
    done_n     = frame_end;
    if (pop) begin
      // Covers both a start from IDLE and the back-to-back restart on the last stop cycle.
      state_n    = START;
      baud_cnt_n = '0;
      bit_cnt_n  = '0;
      shreg_n    = fifo.data_in;
      tx_n       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt_n = '0;
          tx_n       = 1'b1;
        end
        START: begin
          if (baud_last) begin
            state_n    = DATA;
            baud_cnt_n = '0;
            tx_n       = shreg[0];
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt_n = '0;
            if (bit_cnt == DATA_LAST) begin
              state_n   = STOP;
              bit_cnt_n = '0;
              tx_n      = 1'b1;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
              shreg_n   = shreg >> 1;
              tx_n      = shreg_n[0];
            end
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt_n = '0;
            if (bit_cnt == STOP_LAST) begin
              state_n   = IDLE;
              bit_cnt_n = '0;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      done     <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Scoreboard bench for uart_fifo_tx: two instances (1 and 2 stop bits) fed by
// queue-modelled FIFOs; monitors check every frame cycle, done pulses and pop legality.
module tb_uart_fifo_tx;
  localparam int CPB = 4;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic enable1 = 1'b0;
  logic enable2 = 1'b0;
  logic tx1, tx2, busy1, busy2, done1, done2;
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  logic [7:0] fq1[$];
  logic [7:0] fq2[$];
  logic [7:0] eq1[$];
  logic [7:0] eq2[$];
  int         dq1[$];
  int         dq2[$];
  logic       pop1_s = 1'b0;
  logic       pop2_s = 1'b0;

  uart_fifo_tx_if #(.W(8)) fif1 ();
  uart_fifo_tx_if #(.W(8)) fif2 ();

  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .W(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .fifo(fif1),
    .tx(tx1), .busy(busy1), .done(done1)
  );
  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .W(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .fifo(fif2),
    .tx(tx2), .busy(busy2), .done(done2)
  );

  wire [1:0] tx_w   = {tx2, tx1};
  wire [1:0] busy_w = {busy2, busy1};
  wire [1:0] done_w = {done2, done1};
  wire [1:0] pop_w  = {fif2.do_pop, fif1.do_pop};
  wire [1:0] en_w   = {enable2, enable1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int fsize(input int id);
    return (id == 0) ? fq1.size() : fq2.size();
  endfunction

  function automatic int esize(input int id);
    return (id == 0) ? eq1.size() : eq2.size();
  endfunction

  function automatic logic [7:0] epop(input int id);
    if (id == 0) return eq1.pop_front();
    return eq2.pop_front();
  endfunction

  function automatic bit done_due(input int id);
    if (id == 0) return (dq1.size() > 0) && (dq1[0] == cyc);
    return (dq2.size() > 0) && (dq2[0] == cyc);
  endfunction

  task automatic refresh();
    fif1.empty = (fq1.size() == 0);
    if (fq1.size() != 0) fif1.data_in = fq1[0];
    else fif1.data_in = 8'hEE;
    fif2.empty = (fq2.size() == 0);
    if (fq2.size() != 0) fif2.data_in = fq2[0];
    else fif2.data_in = 8'hEE;
  endtask

  task automatic push(input int id, input logic [7:0] b);
    if (id == 0) begin fq1.push_back(b); eq1.push_back(b); end
    else begin fq2.push_back(b); eq2.push_back(b); end
    refresh();
  endtask

  // FIFO model: a strobe seen on the falling edge advances the head after the next rising edge
  always @(negedge clk) begin
    pop1_s <= fif1.do_pop;
    pop2_s <= fif2.do_pop;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (pop1_s && !reset && fq1.size() > 0) void'(fq1.pop_front());
    if (pop2_s && !reset && fq2.size() > 0) void'(fq2.pop_front());
    refresh();
  end

  // A pop is only legal while enabled, out of reset and with data present
  always @(negedge clk) begin
    if (fif1.do_pop) chk("pop1 legal", int'(fif1.do_pop), int'(enable1 && !reset && fq1.size() > 0));
    if (fif2.do_pop) chk("pop2 legal", int'(fif2.do_pop), int'(enable2 && !reset && fq2.size() > 0));
  end

  task automatic frame_chk(input int id);
    logic [7:0]  w;
    logic [10:0] bits;
    int          nbits, act;
    bit          ok;
    w = 8'h00;
    if (esize(id) == 0) fail_now($sformatf("unexpected pop on dut%0d", id + 1));
    else w = epop(id);
    nbits = (id == 0) ? 10 : 11;
    bits = '1;
    bits[8:1] = w;
    bits[0] = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      ok = 1'b1;
      act = 0;
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (reset) begin
          chk($sformatf("reset%0d busy/tx", id + 1), int'({busy_w[id], tx_w[id]}), 1);
          for (int t = 0; t < 1000 && reset; t++) @(negedge clk);
          if (reset) fail_now("reset release timeout");
          else chk($sformatf("post-reset pop%0d", id + 1), int'(pop_w[id]),
                   int'(en_w[id] && fsize(id) > 0));
          return;
        end
        if (ok && (({busy_w[id], tx_w[id]} != {1'b1, bits[k]}) ||
                   (pop_w[id] && !(k == nbits - 1 && j == CPB - 1)))) begin
          ok = 1'b0;
          act = int'({pop_w[id], busy_w[id], tx_w[id]});
        end
      end
      chk($sformatf("dut%0d word %02h bit%0d pop/busy/tx", id + 1, w, k),
          ok ? int'({1'b1, bits[k]}) : act, int'({1'b1, bits[k]}));
    end
    if (id == 0) dq1.push_back(cyc + 1);
    else dq2.push_back(cyc + 1);
  endtask

  task automatic monitor(input int id);
    forever begin
      @(negedge clk);
      if (pop_w[id]) begin
        while (pop_w[id]) frame_chk(id);
      end else begin
        chk($sformatf("idle%0d busy/tx", id + 1), int'({busy_w[id], tx_w[id]}), 1);
      end
    end
  endtask

  task automatic done_mon(input int id);
    bit exp_d;
    forever begin
      @(negedge clk);
      exp_d = done_due(id);
      if (done_w[id] || exp_d) begin
        chk($sformatf("done%0d", id + 1), int'(done_w[id]), int'(exp_d));
        if (exp_d) begin
          if (id == 0) void'(dq1.pop_front());
          else void'(dq2.pop_front());
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial done_mon(0);
  initial done_mon(1);

  task automatic wait_idle(input int id);
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (fsize(id) == 0 && esize(id) == 0 && !busy_w[id]) break;
    end
    if (t >= 3000) fail_now($sformatf("dut%0d drain timeout", id + 1));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    refresh();
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    // single frame
    enable1 = 1'b1;
    push(0, 8'h55);
    wait_idle(0);
    // back-to-back pair
    @(posedge clk); #2;
    push(0, 8'hA3);
    push(0, 8'h0F);
    wait_idle(0);
    // two stop bits
    @(posedge clk); #2;
    enable2 = 1'b1;
    push(1, 8'h00);
    wait_idle(1);
    // held off while disabled, then drained
    @(posedge clk); #2;
    enable1 = 1'b0;
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    repeat (60) @(posedge clk);
    #2 enable1 = 1'b1;
    wait_idle(0);
    // enable dropped during the first frame's data bits
    @(posedge clk); #2;
    push(0, 8'h3C);
    push(0, 8'hC5);
    repeat (10) @(posedge clk);
    #2 enable1 = 1'b0;
    repeat (80) @(posedge clk);
    #2 enable1 = 1'b1;
    wait_idle(0);
    // reset in the middle of a frame
    @(posedge clk); #2;
    push(0, 8'h92);
    push(0, 8'h5A);
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    wait_idle(0);
    chk("fifo1 drained", fsize(0), 0);
    chk("fifo2 drained", fsize(1), 0);
    chk("done1 outstanding", dq1.size(), 0);
    chk("done2 outstanding", dq2.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
